// File: rtl/cpu_pkg.sv
// Shared core types and constants used by the fetch stage.
// Holds default widths, the canonical NOP encoding and the PC step.
package cpu_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_ILEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch stage bus: imem address/data, EX redirect and the
// fetch-to-decode valid/ready handshake plus queue occupancy.
interface fetch_queue_unit_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] iaddr;
  logic [ILEN-1:0] idata;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            fd_valid;
  logic [ILEN-1:0] fd_instr;
  logic [XLEN-1:0] fd_pc;
  logic            fd_ready;
  logic [CW-1:0]   fq_count;

  modport master (
    output iaddr, fd_valid, fd_instr, fd_pc, fq_count,
    input  idata, redir_valid, redir_pc, fd_ready
  );

  modport slave (
    input  iaddr, fd_valid, fd_instr, fd_pc, fq_count,
    output idata, redir_valid, redir_pc, fd_ready
  );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO holding packed {pc, instr} fetch entries.
// Pointers carry an extra wrap bit; flush beats push and pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update with flush taking priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, queues {pc, instr} toward decode.
// Define FETCH_BYPASS_EN for a zero-latency empty-queue bypass.
module fetch_queue_unit
  import cpu_pkg::*;
#(
  parameter int          XLEN     = DEF_XLEN,
  parameter int          ILEN     = DEF_ILEN,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic              clk,
  input logic              reset,
  fetch_queue_unit_if.master fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = XLEN + ILEN;

  logic [XLEN-1:0] fetch_pc;
  logic [W-1:0]    head;
  logic            full;
  logic            empty;
  logic [AW:0]     count;
  logic            pop;
  logic            push;
  logic            q_push;
  logic            byp;

  assign fq.iaddr    = fetch_pc;
  assign fq.fq_count = count;

`ifdef FETCH_BYPASS_EN
  assign byp = empty && !fq.redir_valid && fq.fd_ready;
`else
  assign byp = 1'b0;
`endif

  assign pop    = !empty && fq.fd_ready;
  assign push   = !fq.redir_valid && (!full || pop);
  assign q_push = push && !byp;

  // Head mux: queue head, bypassed fetch word, or NOP.
  always_comb begin
    fq.fd_valid = 1'b0;
    fq.fd_instr = ILEN'(NOP_INSTR);
    fq.fd_pc    = '0;
    unique case (1'b1)
      !empty: begin
        fq.fd_valid = 1'b1;
        fq.fd_instr = head[ILEN-1:0];
        fq.fd_pc    = head[W-1 -: XLEN];
      end
      byp: begin
        fq.fd_valid = 1'b1;
        fq.fd_instr = fq.idata;
        fq.fd_pc    = fetch_pc;
      end
      default: ;
    endcase
  end

  // PC: redirect wins, otherwise step on every fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fetch_pc <= XLEN'(RESET_PC);
    else if (fq.redir_valid)
      fetch_pc <= fq.redir_pc & ~XLEN'(3);
    else if (push)
      fetch_pc <= fetch_pc + XLEN'(PC_STEP);
  end

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (pop),
    .flush (fq.redir_valid),
    .din   ({fetch_pc, fq.idata}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule
